// File: rtl/window_pkg.sv
// Shared state encoding and width helpers for the window address sequencer.
package window_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int aw_of(input int size);
        return $clog2(size);
    endfunction

    function automatic int lw_of(input int k);
        return $clog2(k);
    endfunction

    function automatic int cw_of(input int size);
        return $clog2(size) + 1;
    endfunction

endpackage

// File: rtl/lane_decoder.sv
// One-hot row decoder for a single lane address; all-zero when disabled.
module lane_decoder
    import window_pkg::*;
#(
    parameter int SIZE = 16,
    parameter int AW   = aw_of(SIZE)
) (
    input  logic [AW-1:0]   addr,
    input  logic            en,
    output logic [SIZE-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[addr] = 1'b1;
        end
    end

endmodule

// File: rtl/window_addr_sequencer.sv
// Streams K-wide circular address windows with valid/ready handshake.
// Optional feature: define STALL_CNT_EN to add the 16-bit stall_cnt output.
module window_addr_sequencer
    import window_pkg::*;
#(
    parameter int K    = 4,
    parameter int SIZE = 16,
    parameter int AW   = aw_of(SIZE),
    parameter int LW   = lw_of(K),
    parameter int CW   = cw_of(SIZE)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [AW-1:0]        base_addr,
    input  logic [AW-1:0]        step,
    input  logic [CW-1:0]        num_windows,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [K*AW-1:0]      addr_out,
    output logic [K*SIZE-1:0]    row_sel,
    output logic [SIZE-1:0]      row_hit,
    output logic [SIZE*LW-1:0]   lane_of_row,
    output logic                 busy,
    output logic                 done
`ifdef STALL_CNT_EN
    ,
    output logic [15:0]          stall_cnt
`endif
);

    state_t           state_p0;
    state_t           state_nxt;
    logic             load;
    logic             xfer;
    logic             last;
    logic [AW-1:0]    base_p0;
    logic [AW-1:0]    step_p0;
    logic [AW-1:0]    base_nxt;
    logic [CW-1:0]    rem_p0;
    logic             vld_p0;
    logic [K*AW-1:0]  addr_p0;
    logic [K*AW-1:0]  addr_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_p0 <= IDLE;
        end else begin
            state_p0 <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_p0;
        load      = 1'b0;
        xfer      = vld_p0 && out_ready;
        last      = (rem_p0 == CW'(1));
        case (state_p0)
            IDLE: begin
                if (start) begin
                    if (num_windows != '0) begin
                        load      = 1'b1;
                        state_nxt = RUN;
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            RUN: begin
                if (xfer && last) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next window base; AW-bit truncation provides the circular wrap.
    always_comb begin
        base_nxt = load ? base_addr : (base_p0 + step_p0);
        addr_nxt = '0;
        for (int i = 0; i < K; i++) begin
            addr_nxt[i*AW +: AW] = base_nxt + AW'(i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_p0 <= '0;
            step_p0 <= '0;
            rem_p0  <= '0;
            vld_p0  <= 1'b0;
            addr_p0 <= '0;
        end else if (load) begin
            base_p0 <= base_nxt;
            step_p0 <= step;
            rem_p0  <= num_windows;
            vld_p0  <= 1'b1;
            addr_p0 <= addr_nxt;
        end else if (xfer) begin
            if (!last) begin
                base_p0 <= base_nxt;
                rem_p0  <= rem_p0 - CW'(1);
                addr_p0 <= addr_nxt;
            end else begin
                rem_p0  <= '0;
                vld_p0  <= 1'b0;
            end
        end
    end

    assign out_valid = vld_p0;
    assign addr_out  = addr_p0;
    assign busy      = (state_p0 == RUN);
    assign done      = (state_p0 == DONE);

    // Decoders are gated by the valid flag so idle outputs read as zero.
    for (genvar g = 0; g < K; g++) begin : g_lane
        lane_decoder #(
            .SIZE (SIZE),
            .AW   (AW)
        ) u_dec (
            .addr   (addr_p0[g*AW +: AW]),
            .en     (vld_p0),
            .onehot (row_sel[g*SIZE +: SIZE])
        );
    end

    always_comb begin
        row_hit     = '0;
        lane_of_row = '0;
        for (int r = 0; r < SIZE; r++) begin
            for (int i = 0; i < K; i++) begin
                if (row_sel[i*SIZE + r]) begin
                    row_hit[r]              = 1'b1;
                    lane_of_row[r*LW +: LW] = LW'(i);
                end
            end
        end
    end

`ifdef STALL_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (start && (state_p0 == IDLE)) begin
            stall_cnt <= '0;
        end else if (vld_p0 && !out_ready && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_window_addr_sequencer.sv
// Scoreboard bench for window_addr_sequencer (K=4/SIZE=16 plus K=8/SIZE=8 instance).
module tb_window_addr_sequencer;

    localparam int K   = 4;
    localparam int SIZE = 16;
    localparam int AW  = 4;
    localparam int LW  = 2;
    localparam int CW  = 5;
    localparam int K8  = 8;
    localparam int S8  = 8;
    localparam int AW8 = 3;
    localparam int LW8 = 3;
    localparam int CW8 = 4;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                start;
    logic                out_ready;
    logic                out_valid;
    logic                busy;
    logic                done;
    logic [AW-1:0]       base_addr;
    logic [AW-1:0]       step;
    logic [CW-1:0]       num_windows;
    logic [K*AW-1:0]     addr_out;
    logic [K*SIZE-1:0]   row_sel;
    logic [SIZE-1:0]     row_hit;
    logic [SIZE*LW-1:0]  lane_of_row;

    logic                start8;
    logic                ready8 = 1'b1;
    logic                valid8;
    logic                busy8;
    logic                done8;
    logic [AW8-1:0]      base8;
    logic [AW8-1:0]      step8;
    logic [CW8-1:0]      num8;
    logic [K8*AW8-1:0]   addr8;
    logic [K8*S8-1:0]    rs8;
    logic [S8-1:0]       hit8;
    logic [S8*LW8-1:0]   lor8;
`ifdef STALL_CNT_EN
    logic [15:0]         stall_cnt;
    logic [15:0]         stall_cnt8;
`endif

    typedef struct {
        logic [K*AW-1:0]    addr;
        logic [K*SIZE-1:0]  rs;
        logic [SIZE-1:0]    hit;
        logic [SIZE*LW-1:0] lor;
        bit                 last;
    } win_t;

    typedef struct {
        logic [K8*AW8-1:0]  addr;
        logic [K8*S8-1:0]   rs;
        logic [S8-1:0]      hit;
        logic [S8*LW8-1:0]  lor;
    } win8_t;

    win_t   q[$];
    win8_t  q8[$];
    int     checks = 0;
    int     errors = 0;
    bit     done_pending = 0;
    bit     rand_ready = 0;
    int     stall_model = 0;

    window_addr_sequencer #(.K(K), .SIZE(SIZE)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .base_addr   (base_addr),
        .step        (step),
        .num_windows (num_windows),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .addr_out    (addr_out),
        .row_sel     (row_sel),
        .row_hit     (row_hit),
        .lane_of_row (lane_of_row),
        .busy        (busy),
        .done        (done)
`ifdef STALL_CNT_EN
        ,
        .stall_cnt   (stall_cnt)
`endif
    );

    window_addr_sequencer #(.K(K8), .SIZE(S8)) dut8 (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start8),
        .base_addr   (base8),
        .step        (step8),
        .num_windows (num8),
        .out_valid   (valid8),
        .out_ready   (ready8),
        .addr_out    (addr8),
        .row_sel     (rs8),
        .row_hit     (hit8),
        .lane_of_row (lor8),
        .busy        (busy8),
        .done        (done8)
`ifdef STALL_CNT_EN
        ,
        .stall_cnt   (stall_cnt8)
`endif
    );

    always #5 clk = ~clk;

    function automatic void chk(string nm, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Window w of a command: lane i sits on row (base + w*step + i) mod SIZE.
    function automatic win_t mk_win(int b, int s, int w, bit lst);
        win_t e;
        int   a;
        e.addr = '0; e.rs = '0; e.hit = '0; e.lor = '0; e.last = lst;
        for (int i = 0; i < K; i++) begin
            a = (b + w * s + i) % SIZE;
            e.addr[i*AW +: AW]   = AW'(a);
            e.rs[i*SIZE + a]     = 1'b1;
            e.hit[a]             = 1'b1;
            e.lor[a*LW +: LW]    = LW'(i);
        end
        return e;
    endfunction

    function automatic win8_t mk_win8(int b, int s, int w);
        win8_t e;
        int    a;
        e.addr = '0; e.rs = '0; e.hit = '0; e.lor = '0;
        for (int i = 0; i < K8; i++) begin
            a = (b + w * s + i) % S8;
            e.addr[i*AW8 +: AW8]  = AW8'(a);
            e.rs[i*S8 + a]        = 1'b1;
            e.hit[a]              = 1'b1;
            e.lor[a*LW8 +: LW8]   = LW8'(i);
        end
        return e;
    endfunction

    // Monitor for the main instance.
    initial begin : monitor
        logic [K*AW-1:0]    h_addr;
        logic [K*SIZE-1:0]  h_rs;
        logic [SIZE-1:0]    h_hit;
        logic [SIZE*LW-1:0] h_lor;
        bit                 prev_stall;
        prev_stall = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 0;
                continue;
            end
            chk("done", done, done_pending);
            done_pending = 0;
            chk("valid", out_valid, q.size() > 0);
            chk("busy", busy, q.size() > 0);
`ifdef STALL_CNT_EN
            chk("stall_cnt", stall_cnt, stall_model);
`endif
            if (prev_stall) begin
                chk("hold_addr", addr_out, h_addr);
                chk("hold_row_sel", row_sel, h_rs);
                chk("hold_row_hit", row_hit, h_hit);
                chk("hold_lane_of_row", lane_of_row, h_lor);
            end
            prev_stall = 0;
            if (out_valid && q.size() > 0) begin
                chk("addr_out", addr_out, q[0].addr);
                chk("row_sel", row_sel, q[0].rs);
                chk("row_hit", row_hit, q[0].hit);
                chk("lane_of_row", lane_of_row, q[0].lor);
                if (out_ready) begin
                    if (q[0].last) done_pending = 1;
                    void'(q.pop_front());
                end else begin
                    prev_stall = 1;
                    h_addr = addr_out; h_rs = row_sel; h_hit = row_hit; h_lor = lane_of_row;
                    if (stall_model < 65535) stall_model++;
                end
            end else if (!out_valid) begin
                chk("idle_row_sel", row_sel, 0);
                chk("idle_lane_of_row", lane_of_row, 0);
            end
        end
    end

    // Monitor for the K == SIZE instance (consumer always ready).
    initial begin : monitor8
        win8_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) continue;
            chk("valid8", valid8, q8.size() > 0);
            chk("busy8", busy8, q8.size() > 0);
            chk("done8_with_valid8", done8 & valid8, 0);
            if (valid8 && q8.size() > 0) begin
                e = q8.pop_front();
                chk("addr8", addr8, e.addr);
                chk("row_sel8", rs8, e.rs);
                chk("row_hit8", hit8, e.hit);
                chk("lane_of_row8", lor8, e.lor);
            end
        end
    end

    initial begin : ready_driver
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: time limit reached with %0d windows outstanding", q.size());
        $fatal(1, "watchdog expired");
    end

    task automatic issue(input int b, input int s, input int n);
        @(posedge clk);
        #1;
        start = 1'b1; base_addr = AW'(b); step = AW'(s); num_windows = CW'(n);
        @(posedge clk);
        #1;
        start = 1'b0;
        stall_model = 0;
        if (n == 0) done_pending = 1;
        for (int w = 0; w < n; w++) q.push_back(mk_win(b, s, w, w == n - 1));
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            #1;
            if (q.size() == 0 && !done_pending && !busy && !done) return;
        end
        checks++;
        errors++;
        $display("FAIL wait_idle: timeout with %0d windows outstanding, required 0", q.size());
        q.delete();
        done_pending = 0;
    endtask

    initial begin : stimulus
        rst_n = 1'b1; start = 1'b0; out_ready = 1'b0;
        base_addr = '0; step = '0; num_windows = '0;
        start8 = 1'b0; base8 = '0; step8 = '0; num8 = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_addr", addr_out, 0);
        chk("rst_row_hit", row_hit, 0);
        chk("rst_lane_of_row", lane_of_row, 0);
        #9 rst_n = 1'b1;

        // Wrapping window pair, consumer always ready.
        out_ready = 1'b1;
        issue(14, 4, 2);
        chk("w0_addr_const", addr_out, 16'h10FE);
        chk("w0_row_hit_const", row_hit, 16'hC003);
        chk("w0_lane_of_row_const", lane_of_row, 32'h4000_000E);
        wait_idle();

        // Three stall cycles on window0, with an ignored start during RUN.
        out_ready = 1'b0;
        issue(14, 4, 2);
        start = 1'b1; base_addr = 4'd5; step = 4'd1; num_windows = 5'd3;
        repeat (3) @(posedge clk);
        #1;
        start = 1'b0;
`ifdef STALL_CNT_EN
        chk("stall_cnt_after_3", stall_cnt, 3);
`endif
        out_ready = 1'b1;
        wait_idle();

        // Zero-window command: straight to a single done pulse.
        issue(3, 1, 0);
        wait_idle();

        // Start presented during the DONE cycle is ignored.
        issue(0, 1, 1);
        @(posedge clk);
        #1;
        start = 1'b1; base_addr = 4'd7; step = 4'd2; num_windows = 5'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle();

        // Asynchronous abort after one transfer.
        issue(14, 4, 4);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        q.delete();
        done_pending = 0;
        stall_model = 0;
        #1;
        chk("abort_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_addr", addr_out, 0);
        chk("abort_row_hit", row_hit, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        issue(9, 3, 3);
        wait_idle();

        // K == SIZE instance: every window covers all rows.
        @(posedge clk);
        #1;
        start8 = 1'b1; base8 = 3'd3; step8 = 3'd1; num8 = 4'd3;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        for (int w = 0; w < 3; w++) q8.push_back(mk_win8(3, 1, w));
        for (int c = 0; c < 50 && (q8.size() != 0 || busy8 || done8); c++) @(negedge clk);
        chk("q8_drained", q8.size(), 0);

        // Randomized commands with a randomly stalling consumer.
        rand_ready = 1;
        for (int t = 0; t < 25; t++) begin
            issue($urandom_range(0, SIZE - 1), $urandom_range(0, SIZE - 1), $urandom_range(0, 6));
            wait_idle();
        end
        rand_ready = 0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("q_drained", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
